// File: rtl/rst_req_ctrl.sv
// Soft-reset request controller: merges core requests, a debounced reset button and
// watchdog expiry into timed core/system reset pulses, with sticky cause flags.
module rst_req_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 8
) (
  input  logic       sys_clk,
  input  logic       mcu_rst_signal,
  input  logic [1:0] core_soft_rst_req,
  input  logic       btn_rst_n,
  input  logic       wdt_timeout,
  input  logic       cause_clr,
  output logic [1:0] soft_rst_out,
  output logic [3:0] rst_cause,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    ASSERT_CORE,
    ASSERT_SYS,
    WAIT_LOW
  } state_t;

  localparam logic [15:0] DEB_LAST  = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]  HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [7:0]  hold_reg, hold_next;
  logic        pending_reg, pending_next;
  logic [3:0]  cause_reg;
  logic [3:0]  cause_set;
  logic [1:0]  soft_rst_reg;
  logic [1:0]  soft_rst_dec;

  logic        btn_meta_reg, btn_sync_reg;
  logic        btn_stable_reg, btn_armed_reg;
  logic [15:0] deb_cnt_reg;
  logic        deb_accept;
  logic        btn_event;

  logic [1:0]  req_d_reg;
  logic        req_valid_reg;
  logic [1:0]  core_edge;
  logic        sys_event;
  logic        sys_req;

  // Button input is asynchronous; two-flop synchronizer, idle level is released (high).
  always_ff @(posedge sys_clk or negedge mcu_rst_signal) begin
    if (!mcu_rst_signal) begin
      btn_meta_reg <= 1'b1;
      btn_sync_reg <= 1'b1;
    end else begin
      btn_meta_reg <= btn_rst_n;
      btn_sync_reg <= btn_meta_reg;
    end
  end

  // The counter tracks consecutive samples differing from the accepted level; any
  // sample matching the accepted level restarts it.
  assign deb_accept = (btn_sync_reg != btn_stable_reg) && (deb_cnt_reg == DEB_LAST);
  assign btn_event  = deb_accept && !btn_sync_reg && btn_armed_reg;

  always_ff @(posedge sys_clk or negedge mcu_rst_signal) begin
    if (!mcu_rst_signal) begin
      btn_stable_reg <= 1'b1;
      btn_armed_reg  <= 1'b1;
      deb_cnt_reg    <= '0;
    end else if (btn_sync_reg == btn_stable_reg) begin
      deb_cnt_reg <= '0;
    end else if (deb_accept) begin
      btn_stable_reg <= btn_sync_reg;
      btn_armed_reg  <= btn_sync_reg;
      deb_cnt_reg    <= '0;
    end else begin
      deb_cnt_reg <= deb_cnt_reg + 16'd1;
    end
  end

  // req_valid masks the first capture after reset so held requests are not seen as edges.
  always_ff @(posedge sys_clk or negedge mcu_rst_signal) begin
    if (!mcu_rst_signal) begin
      req_d_reg     <= 2'b00;
      req_valid_reg <= 1'b0;
    end else begin
      req_d_reg     <= core_soft_rst_req;
      req_valid_reg <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_edge
    assign core_edge[gi] = core_soft_rst_req[gi] & ~req_d_reg[gi] & req_valid_reg;
  end

  assign sys_event = btn_event | wdt_timeout;
  assign sys_req   = core_edge[1] | sys_event;

  always_comb begin
    state_next   = state_reg;
    hold_next    = hold_reg;
    pending_next = pending_reg;
    cause_set    = 4'b0000;
    case (state_reg)
      IDLE: begin
        if (sys_req || pending_reg) begin
          state_next   = ASSERT_SYS;
          hold_next    = HOLD_LOAD;
          pending_next = 1'b0;
          cause_set    = {wdt_timeout, btn_event, core_edge[1], core_edge[0]};
        end else if (core_edge[0]) begin
          state_next   = ASSERT_CORE;
          hold_next    = HOLD_LOAD;
          cause_set[0] = 1'b1;
        end
      end
      ASSERT_CORE: begin
        if (sys_req) begin
          state_next   = ASSERT_SYS;
          hold_next    = HOLD_LOAD;
          pending_next = 1'b0;
          cause_set    = {wdt_timeout, btn_event, core_edge[1], 1'b0};
        end else if (hold_reg == 8'd0) begin
          state_next = WAIT_LOW;
        end else begin
          hold_next = hold_reg - 8'd1;
        end
      end
      ASSERT_SYS: begin
        if (hold_reg == 8'd0) begin
          state_next = WAIT_LOW;
        end else begin
          hold_next = hold_reg - 8'd1;
        end
        if (sys_event) begin
          pending_next = 1'b1;
        end
        cause_set[3:2] = {wdt_timeout, btn_event};
      end
      WAIT_LOW: begin
        if (core_soft_rst_req == 2'b00) begin
          state_next = IDLE;
        end
        if (sys_event) begin
          pending_next = 1'b1;
        end
        cause_set[3:2] = {wdt_timeout, btn_event};
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    soft_rst_dec = 2'b00;
    case (state_reg)
      ASSERT_CORE: soft_rst_dec = 2'b01;
      ASSERT_SYS:  soft_rst_dec = 2'b10;
      default:     soft_rst_dec = 2'b00;
    endcase
  end

  // Output is registered from the current state, so a request taken at edge N
  // drives soft_rst_out from edge N+1 for HOLD_CYCLES cycles.
  always_ff @(posedge sys_clk or negedge mcu_rst_signal) begin
    if (!mcu_rst_signal) begin
      state_reg    <= IDLE;
      hold_reg     <= '0;
      pending_reg  <= 1'b0;
      cause_reg    <= 4'b0000;
      soft_rst_reg <= 2'b00;
    end else begin
      state_reg    <= state_next;
      hold_reg     <= hold_next;
      pending_reg  <= pending_next;
      cause_reg    <= (cause_clr ? 4'b0000 : cause_reg) | cause_set;
      soft_rst_reg <= soft_rst_dec;
    end
  end

  assign soft_rst_out = soft_rst_reg;
  assign rst_cause    = cause_reg;
  assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_rst_req_ctrl.sv
// Directed bench for rst_req_ctrl: per-cycle vector table for the request/FSM paths,
// plus hand-written button debounce and asynchronous reset sequences.
module tb_rst_req_ctrl;

  logic       sys_clk = 1'b0;
  logic       mcu_rst_signal = 1'b0;
  logic [1:0] core_soft_rst_req = 2'b00;
  logic       btn_rst_n = 1'b1;
  logic       wdt_timeout = 1'b0;
  logic       cause_clr = 1'b0;
  logic [1:0] soft_rst_out;
  logic [3:0] rst_cause;
  logic       busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] req;
    logic       wdt;
    logic       clr;
    logic [1:0] out;
    logic [3:0] cause;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  int hi_cnt;
  int rise_cnt;
  int core_cnt;
  int bad_cnt;
  logic prev_hi;

  rst_req_ctrl #(
    .DEBOUNCE_CYCLES(16),
    .HOLD_CYCLES(8)
  ) dut (
    .sys_clk(sys_clk),
    .mcu_rst_signal(mcu_rst_signal),
    .core_soft_rst_req(core_soft_rst_req),
    .btn_rst_n(btn_rst_n),
    .wdt_timeout(wdt_timeout),
    .cause_clr(cause_clr),
    .soft_rst_out(soft_rst_out),
    .rst_cause(rst_cause),
    .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic void add(logic [1:0] req, logic wdt, logic clr,
                              logic [1:0] out, logic [3:0] cause, logic busy_e);
    vec_t v;
    v.req   = req;
    v.wdt   = wdt;
    v.clr   = clr;
    v.out   = out;
    v.cause = cause;
    v.busy  = busy_e;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, int idx, int got, int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s idx=%0d got=%0d want=%0d", name, idx, got, want);
    end
  endtask

  task automatic step(logic [1:0] req, logic wdt, logic clr, logic btn);
    core_soft_rst_req = req;
    wdt_timeout       = wdt;
    cause_clr         = clr;
    btn_rst_n         = btn;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic watch();
    if (soft_rst_out[1]) begin
      hi_cnt++;
      if (!prev_hi) rise_cnt++;
    end
    if (soft_rst_out[0]) core_cnt++;
    prev_hi = soft_rst_out[1];
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_out", 0, int'(soft_rst_out), 0);
    check("rst_cause", 0, int'(rst_cause), 0);
    check("rst_busy", 0, int'(busy), 0);
    #2 mcu_rst_signal = 1'b1;

    // Core request: 8-cycle core pulse, WAIT_LOW until released
    add(2'b00, 0, 0, 2'b00, 4'b0000, 0);
    add(2'b01, 0, 0, 2'b00, 4'b0001, 1);
    for (int i = 0; i < 8; i++) add(2'b01, 0, 0, 2'b01, 4'b0001, 1);
    add(2'b01, 0, 0, 2'b00, 4'b0001, 1);
    add(2'b00, 0, 0, 2'b00, 4'b0001, 0);
    add(2'b00, 0, 0, 2'b00, 4'b0001, 0);
    // Upgrade core -> system by wdt three cycles after the core edge
    add(2'b00, 0, 1, 2'b00, 4'b0000, 0);
    add(2'b01, 0, 0, 2'b00, 4'b0001, 1);
    add(2'b01, 0, 0, 2'b01, 4'b0001, 1);
    add(2'b01, 0, 0, 2'b01, 4'b0001, 1);
    add(2'b01, 1, 0, 2'b01, 4'b1001, 1);
    for (int i = 0; i < 8; i++) add(2'b01, 0, 0, 2'b10, 4'b1001, 1);
    add(2'b01, 0, 0, 2'b00, 4'b1001, 1);
    add(2'b00, 0, 0, 2'b00, 4'b1001, 0);
    // wdt in WAIT_LOW becomes pending, serviced right after IDLE
    add(2'b00, 0, 1, 2'b00, 4'b0000, 0);
    add(2'b01, 0, 0, 2'b00, 4'b0001, 1);
    for (int i = 0; i < 8; i++) add(2'b01, 0, 0, 2'b01, 4'b0001, 1);
    add(2'b01, 1, 0, 2'b00, 4'b1001, 1);
    add(2'b00, 0, 0, 2'b00, 4'b1001, 0);
    add(2'b00, 0, 0, 2'b00, 4'b1001, 1);
    for (int i = 0; i < 8; i++) add(2'b00, 0, 0, 2'b10, 4'b1001, 1);
    add(2'b00, 0, 0, 2'b00, 4'b1001, 0);
    // cause_clr together with wdt acceptance: the set wins
    add(2'b00, 1, 1, 2'b00, 4'b1000, 1);
    for (int i = 0; i < 8; i++) add(2'b00, 0, 0, 2'b10, 4'b1000, 1);
    add(2'b00, 0, 0, 2'b00, 4'b1000, 0);
    // Both core bits at once: system wins, both causes set; core edge mid-pulse dropped
    add(2'b00, 0, 1, 2'b00, 4'b0000, 0);
    add(2'b11, 0, 0, 2'b00, 4'b0011, 1);
    add(2'b11, 0, 0, 2'b10, 4'b0011, 1);
    add(2'b11, 0, 0, 2'b10, 4'b0011, 1);
    add(2'b11, 0, 1, 2'b10, 4'b0000, 1);
    add(2'b10, 0, 0, 2'b10, 4'b0000, 1);
    add(2'b11, 0, 0, 2'b10, 4'b0000, 1);
    add(2'b11, 0, 0, 2'b10, 4'b0000, 1);
    add(2'b11, 0, 0, 2'b10, 4'b0000, 1);
    add(2'b11, 0, 0, 2'b10, 4'b0000, 1);
    add(2'b11, 0, 0, 2'b00, 4'b0000, 1);
    add(2'b00, 0, 0, 2'b00, 4'b0000, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].req, vecs[i].wdt, vecs[i].clr, 1'b1);
      $display("vec %0d req=%b wdt=%b clr=%b out=%b cause=%b busy=%b",
               i, vecs[i].req, vecs[i].wdt, vecs[i].clr, soft_rst_out, rst_cause, busy);
      check("vec_out", i, int'(soft_rst_out), int'(vecs[i].out));
      check("vec_cause", i, int'(rst_cause), int'(vecs[i].cause));
      check("vec_busy", i, int'(busy), int'(vecs[i].busy));
    end

    // Button: 10-cycle glitch ignored, 20-cycle press gives one 8-cycle system pulse
    step(2'b00, 0, 1, 1'b1);
    hi_cnt = 0; rise_cnt = 0; core_cnt = 0; prev_hi = 1'b0;
    for (int i = 0; i < 10; i++) begin step(2'b00, 0, 0, 1'b0); watch(); end
    for (int i = 0; i < 30; i++) begin step(2'b00, 0, 0, 1'b1); watch(); end
    $display("btn glitch: pulse cycles=%0d cause=%b", hi_cnt, rst_cause);
    check("btn_glitch_pulse", 0, hi_cnt, 0);
    check("btn_glitch_cause", 0, int'(rst_cause), 0);
    hi_cnt = 0; rise_cnt = 0; core_cnt = 0; prev_hi = 1'b0;
    for (int i = 0; i < 20; i++) begin step(2'b00, 0, 0, 1'b0); watch(); end
    for (int i = 0; i < 40; i++) begin step(2'b00, 0, 0, 1'b1); watch(); end
    $display("btn press: pulse cycles=%0d pulses=%0d cause=%b", hi_cnt, rise_cnt, rst_cause);
    check("btn_pulse_len", 0, hi_cnt, 8);
    check("btn_pulse_count", 0, rise_cnt, 1);
    check("btn_core_out", 0, core_cnt, 0);
    check("btn_cause", 0, int'(rst_cause), 4'b0100);
    check("btn_busy_end", 0, int'(busy), 0);

    // Asynchronous reset mid-ASSERT_SYS, then held request must not pulse
    step(2'b00, 0, 1, 1'b1);
    step(2'b00, 1, 0, 1'b1);
    step(2'b00, 0, 0, 1'b1);
    step(2'b00, 0, 0, 1'b1);
    step(2'b00, 0, 0, 1'b1);
    check("pre_rst_out", 0, int'(soft_rst_out), 2'b10);
    #3 mcu_rst_signal = 1'b0;
    #1;
    $display("async reset: out=%b busy=%b cause=%b", soft_rst_out, busy, rst_cause);
    check("async_rst_out", 0, int'(soft_rst_out), 0);
    check("async_rst_busy", 0, int'(busy), 0);
    check("async_rst_cause", 0, int'(rst_cause), 0);
    core_soft_rst_req = 2'b10;
    wdt_timeout = 1'b0;
    repeat (2) @(posedge sys_clk);
    #3 mcu_rst_signal = 1'b1;
    bad_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      step(2'b10, 0, 0, 1'b1);
      if (soft_rst_out != 2'b00 || busy) bad_cnt++;
    end
    $display("after release held 10: active cycles=%0d", bad_cnt);
    check("held_req_no_pulse", 0, bad_cnt, 0);
    step(2'b00, 0, 0, 1'b1);
    step(2'b10, 0, 0, 1'b1);
    check("post_rst_busy", 0, int'(busy), 1);
    check("post_rst_cause", 0, int'(rst_cause), 4'b0010);
    step(2'b10, 0, 0, 1'b1);
    $display("fresh sys edge: out=%b cause=%b", soft_rst_out, rst_cause);
    check("post_rst_out", 0, int'(soft_rst_out), 2'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
